// File: rtl/uart_seq_pkg.sv
// Shared types and helpers for the UART command sequencer: FSM states, 50 MHz baud divisors,
// and the nibble-to-ASCII conversion used when payload bytes are sent as hex text.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FRAME = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } seq_state_t;

    // clk cycles per bit at 50 MHz
    localparam int B115200 = 434;
    localparam int B57600  = 868;
    localparam int B38400  = 1302;
    localparam int B19200  = 2604;
    localparam int B9600   = 5208;
    localparam int B4800   = 10417;
    localparam int B2400   = 20833;
    localparam int B1200   = 41667;
    localparam int B300    = 166667;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/seq_uart_tx.sv
// 8N1 serializer, LSB first. A load pulse while idle starts a frame; frame_done is high
// during the last cycle of the stop bit.
module seq_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       frame_done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          bit_end;

    assign bit_end    = active && (baud_cnt == BAUD_LAST);
    assign frame_done = bit_end && (bit_cnt == 4'd9);

    // shreg carries the stop bit above the data so the ninth shift presents it on tx
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (!active) begin
            if (load) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shreg    <= {1'b1, byte_in};
                bit_cnt  <= '0;
                baud_cnt <= '0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Streams a parameter-held command script over UART with N_DATA payload bytes spliced in before
// ROM index INSERT_AT. Define HEX_ASCII_EN to send each payload byte as two upper-case hex chars.
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int                     CLKS_PER_BIT = B115200,
    parameter int                     ROM_DEPTH    = 22,
    parameter logic [8*ROM_DEPTH-1:0] ROM_INIT     = '0,  // byte 0 in the low byte
    parameter int                     N_DATA       = 1,
    parameter int                     INSERT_AT    = 20,
    parameter int                     GAP_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*N_DATA-1:0] data,
    output logic                tx,
    output logic                busy,
    output logic                done
);
`ifdef HEX_ASCII_EN
    localparam int PAY_FRAMES = 2 * N_DATA;
`else
    localparam int PAY_FRAMES = N_DATA;
`endif
    localparam int TOTAL = ROM_DEPTH + PAY_FRAMES;
    localparam int IW    = $clog2(ROM_DEPTH + 2*N_DATA + 1);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_t          state, state_n;
    logic [IW-1:0]       idx;
    logic [GW-1:0]       gap_cnt;
    logic [8*N_DATA-1:0] payload;
    logic [7:0]          cur_byte;
    logic                load, frame_done, last_byte;

    assign last_byte = (idx == IW'(TOTAL - 1));
    assign busy      = (state != IDLE) && (state != FIN);

    always_comb begin
        int i, p;
`ifdef HEX_ASCII_EN
        logic [7:0] sel;
        sel = 8'h00;
`endif
        i        = int'(idx);
        p        = 0;
        cur_byte = 8'h00;
        if (i < INSERT_AT) begin
            cur_byte = ROM_INIT[8*i +: 8];
        end else if (i < INSERT_AT + PAY_FRAMES) begin
            p = i - INSERT_AT;
`ifdef HEX_ASCII_EN
            sel      = payload[8*(N_DATA-1-p/2) +: 8];
            cur_byte = nib2ascii(p[0] ? sel[3:0] : sel[7:4]);
`else
            cur_byte = payload[8*(N_DATA-1-p) +: 8];
`endif
        end else begin
            cur_byte = ROM_INIT[8*(i-PAY_FRAMES) +: 8];
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:  if (start) state_n = LOAD;
            LOAD:  begin load = 1'b1; state_n = FRAME; end
            FRAME: if (frame_done) begin
                if (last_byte)            state_n = FIN;
                else if (GAP_CYCLES == 0) state_n = LOAD;
                else                      state_n = GAP;
            end
            GAP:   if (gap_cnt == GAP_LAST) state_n = LOAD;
            FIN:   begin done = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            payload <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                payload <= data;
                idx     <= '0;
            end else if (state == FRAME && frame_done && !last_byte) begin
                idx <= idx + 1'b1;
            end
        end
    end

    seq_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .byte_in    (cur_byte),
        .tx         (tx),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: three instances (payload in the middle with gaps, payload first,
// payload last), a UART decoder per instance, and a list-based model of the expected byte stream.
module tb_uart_cmd_sequencer;
    localparam int CPB  = 4;
    localparam int RD   = 3;
    localparam int ND   = 2;
    localparam int NDUT = 3;
    localparam logic [8*RD-1:0] ROMI = 24'h0D5441;
    localparam int INS [NDUT] = '{2, 0, 3};
    localparam int GAPC[NDUT] = '{8, 0, 0};

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          k;
        logic [15:0] d;
        int          n;
        logic [55:0] exp;
        int          dend;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] start;
    logic [15:0]     data [NDUT];
    logic [NDUT-1:0] tx, busy, done;
    int              cyc = 0;
    int              tests = 0, fails = 0;

    logic [7:0] dec_q [NDUT][$];
    int         st_q  [NDUT][$];
    int         done_cnt[NDUT], done_cyc[NDUT], busy_cnt[NDUT], err_cnt[NDUT], s_cyc[NDUT];
    bit         busy_at_done[NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_sequencer #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(RD), .ROM_INIT(ROMI), .N_DATA(ND),
        .INSERT_AT(INS[0]), .GAP_CYCLES(GAPC[0])) u0 (.clk(clk), .rst(rst), .start(start[0]),
        .data(data[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_cmd_sequencer #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(RD), .ROM_INIT(ROMI), .N_DATA(ND),
        .INSERT_AT(INS[1]), .GAP_CYCLES(GAPC[1])) u1 (.clk(clk), .rst(rst), .start(start[1]),
        .data(data[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_cmd_sequencer #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(RD), .ROM_INIT(ROMI), .N_DATA(ND),
        .INSERT_AT(INS[2]), .GAP_CYCLES(GAPC[2])) u2 (.clk(clk), .rst(rst), .start(start[2]),
        .data(data[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

`ifdef HEX_ASCII_EN
    function automatic logic [7:0] hexc(input logic [3:0] n);
        string h;
        h = "0123456789ABCDEF";
        return h[n];
    endfunction
`endif

    // Expected stream: ROM head, payload (raw or as hex text), ROM tail
    function automatic bq_t model(input int ins, input logic [15:0] d);
        bq_t        q, pay;
        logic [7:0] b;
        for (int j = 0; j < ND; j++) begin
            b = d[8*(ND-1-j) +: 8];
`ifdef HEX_ASCII_EN
            pay.push_back(hexc(b[7:4]));
            pay.push_back(hexc(b[3:0]));
`else
            pay.push_back(b);
`endif
        end
        for (int i = 0; i < ins; i++) q.push_back(ROMI[8*i +: 8]);
        foreach (pay[j]) q.push_back(pay[j]);
        for (int i = ins; i < RD; i++) q.push_back(ROMI[8*i +: 8]);
        return q;
    endfunction

    // First start bit 2 cycles after start; frames 10*CPB long; spacing 10*CPB+gap+1; done ends 1 later
    function automatic int exp_end(input int n, input int gap);
        return 2 + (n - 1) * (10*CPB + gap + 1) + 10*CPB + 1;
    endfunction

    task automatic decoder(input int k);
        logic [9:0] bits;
        logic       s;
        bit         ab, bad;
        forever begin
            @(negedge clk);
            if (rst || tx[k]) continue;
            st_q[k].push_back(cyc);
            ab = 0; bad = 0; s = 1'b0;
            for (int b = 0; b < 10; b++) begin
                for (int j = 0; j < CPB; j++) begin
                    if (b != 0 || j != 0) @(negedge clk);
                    if (rst) ab = 1;
                    if (j == 0) s = tx[k];
                    else if (tx[k] !== s) bad = 1;
                end
                bits[b] = s;
            end
            if (!ab) begin
                if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1) err_cnt[k]++;
                dec_q[k].push_back(bits[8:1]);
            end
        end
    endtask

    initial decoder(0);
    initial decoder(1);
    initial decoder(2);

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (done[k] === 1'b1) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
                if (busy[k] !== 1'b0) busy_at_done[k] = 1;
            end
            if (busy[k] === 1'b1) busy_cnt[k]++;
        end
    end

    task automatic pulse_start(input int k, input logic [15:0] d);
        @(posedge clk); #1;
        dec_q[k].delete();
        st_q[k].delete();
        done_cnt[k] = 0; busy_cnt[k] = 0; err_cnt[k] = 0; busy_at_done[k] = 0;
        s_cyc[k] = cyc;
        data[k]  = d;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string nm);
        int n;
        n = 0;
        while (done_cnt[k] == 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, ".done_seen"}, (done_cnt[k] > 0), 1);
    endtask

    task automatic check_txn(input int k, input bq_t e, input int dend, input string nm);
        int bad;
        chk({nm, ".nframes"}, dec_q[k].size(), e.size());
        for (int i = 0; i < e.size() && i < dec_q[k].size(); i++)
            chk($sformatf("%s.byte%0d", nm, i), dec_q[k][i], e[i]);
        if (st_q[k].size() > 0) chk({nm, ".latency"}, st_q[k][0] - s_cyc[k], 2);
        else                    chk({nm, ".latency"}, -1, 2);
        bad = 0;
        for (int i = 1; i < st_q[k].size(); i++)
            if (st_q[k][i] - st_q[k][i-1] != 10*CPB + GAPC[k] + 1) bad++;
        chk({nm, ".spacing_errs"}, bad, 0);
        chk({nm, ".done_count"}, done_cnt[k], 1);
        chk({nm, ".done_end"}, done_cyc[k] + 1 - s_cyc[k], dend);
        chk({nm, ".busy_cycles"}, busy_cnt[k], dend - 2);
        chk({nm, ".busy_at_done"}, busy_at_done[k], 0);
        chk({nm, ".frame_errs"}, err_cnt[k], 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[3];
        bq_t  q;
        int   c1, n, k;
        logic [15:0] d;

`ifdef HEX_ASCII_EN
        vecs[0] = '{0, 16'h3AF0, 7, 56'h41_54_33_41_46_30_0D, 337};
        vecs[1] = '{1, 16'h3AF0, 7, 56'h33_41_46_30_41_54_0D, 289};
        vecs[2] = '{2, 16'h3AF0, 7, 56'h41_54_0D_33_41_46_30, 289};
`else
        vecs[0] = '{0, 16'h1234, 5, 56'h41_54_12_34_0D, 239};
        vecs[1] = '{1, 16'h1234, 5, 56'h12_34_41_54_0D, 207};
        vecs[2] = '{2, 16'h1234, 5, 56'h41_54_0D_12_34, 207};
`endif
        rst = 1'b1;
        start = '0;
        for (int i = 0; i < NDUT; i++) begin
            data[i] = '0; done_cnt[i] = 0; busy_cnt[i] = 0; err_cnt[i] = 0; s_cyc[i] = 0;
            done_cyc[i] = 0; busy_at_done[i] = 0;
        end
        wait_cycles(3);
        @(negedge clk);
        chk("reset.tx", tx, 3'b111);
        chk("reset.busy", busy, 3'b000);
        chk("reset.done", done, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(2);

        // Directed vectors: spec stimulus on each insertion point
        for (int v = 0; v < 3; v++) begin
            q = {};
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].exp[8*(vecs[v].n-1-i) +: 8]);
            pulse_start(vecs[v].k, vecs[v].d);
            wait_done(vecs[v].k, $sformatf("vec%0d", v));
            wait_cycles(5);
            check_txn(vecs[v].k, q, vecs[v].dend, $sformatf("vec%0d", v));
        end

        // Start and data re-driven during the third frame must be ignored
        pulse_start(0, 16'h1234);
        n = 0;
        while (st_q[0].size() < 3 && n < 2000) begin @(negedge clk); #1; n++; end
        chk("restart.third_frame_seen", (st_q[0].size() >= 3), 1);
        wait_cycles(5);
        data[0] = 16'hFFFF; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, "restart");
        q = model(INS[0], 16'h1234);
        check_txn(0, q, vecs[0].dend, "restart");
        pulse_start(0, 16'hA55A);
        @(negedge clk);
        chk("restart.accept_after_done", busy[0], 1'b1);
        wait_done(0, "back2back");
        wait_cycles(5);
        check_txn(0, model(INS[0], 16'hA55A), exp_end(model(INS[0], 16'hA55A).size(), GAPC[0]),
                  "back2back");

        // Reset during bit 5 of the second frame
        pulse_start(0, 16'h1234);
        n = 0;
        while (st_q[0].size() < 2 && n < 2000) begin @(negedge clk); #1; n++; end
        chk("abort.second_frame_seen", (st_q[0].size() >= 2), 1);
        c1 = (st_q[0].size() >= 2) ? st_q[0][1] : cyc;
        n = 0;
        while (cyc < c1 + 21 && n < 100) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.tx", tx[0], 1'b1);
        chk("abort.busy", busy[0], 1'b0);
        wait_cycles(60);
        chk("abort.no_done", done_cnt[0], 0);
        pulse_start(0, 16'h1234);
        wait_done(0, "after_abort");
        wait_cycles(5);
        check_txn(0, model(INS[0], 16'h1234), vecs[0].dend, "after_abort");

        // Random payloads on random instances; data scrambled while busy
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(0, NDUT - 1);
            d = 16'($urandom);
            pulse_start(k, d);
            wait_cycles(3);
            data[k] = 16'($urandom);
            wait_done(k, $sformatf("rand%0d", r));
            wait_cycles(5);
            q = model(INS[k], d);
            check_txn(k, q, exp_end(q.size(), GAPC[k]), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
